// File: rtl/sram_100_qsys_cpu_oci_monitor_access.sv
// sram_100_qsys_cpu_oci_monitor_access
// Sysclk-side executor for the JTAG debug module's memory commands. Holds the
// monitor address register (MonAReg, auto-incrementing) and the monitor data
// register (MonDReg), and performs one word read or write per accepted command
// on a simple request/waitrequest master port.
//
// Optional feature: define SRAM_100_QSYS_CPU_OCI_TIMEOUT_EN to abort an access
// after TIMEOUT consecutive stalled cycles and flag monitor_error. With the
// macro undefined, accesses wait indefinitely and monitor_error stays 0.
//
// Handshake: a request (mem_read or mem_write) is held, with mem_address and
// mem_writedata stable, until the cycle in which mem_waitrequest is low; that
// cycle's clock edge completes the transfer. A reset abandons the request.
//
// The FSM state is held in state_q for observation by bound checkers.
module sram_100_qsys_cpu_oci_monitor_access #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mon_a_q, mon_a_d;
  logic [31:0]         mon_d_q, mon_d_d;
  logic                inc_q, inc_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;

`ifdef SRAM_100_QSYS_CPU_OCI_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0]          wait_cnt_q, wait_cnt_d;
`endif

  // jdo bits outside the address and data fields carry no meaning here.
  logic unused_jdo_bits;
  assign unused_jdo_bits = ^{jdo[37:35], jdo[2:0]};

  // Command decode, completion and (optionally) timeout handling.
  always_comb begin
    state_d = state_q;
    mon_a_d = mon_a_q;
    mon_d_d = mon_d_q;
    inc_d   = inc_q;
    ready_d = ready_q;
    error_d = error_q;
`ifdef SRAM_100_QSYS_CPU_OCI_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (take_action_ocimem_b) begin
          mon_d_d = jdo[34:3];
          inc_d   = 1'b1;
          state_d = S_WRITE;
          ready_d = 1'b0;
          error_d = 1'b0;
`ifdef SRAM_100_QSYS_CPU_OCI_TIMEOUT_EN
          wait_cnt_d = 8'd0;
`endif
        end else if (take_action_ocimem_a) begin
          mon_a_d = jdo[25:26-ADDR_W];
          // An address load alone leaves the status flags untouched.
          if (jdo[34]) begin
            inc_d   = 1'b0;
            state_d = S_READ;
            ready_d = 1'b0;
            error_d = 1'b0;
`ifdef SRAM_100_QSYS_CPU_OCI_TIMEOUT_EN
            wait_cnt_d = 8'd0;
`endif
          end
        end else if (take_no_action_ocimem_a) begin
          inc_d   = 1'b1;
          state_d = S_READ;
          ready_d = 1'b0;
          error_d = 1'b0;
`ifdef SRAM_100_QSYS_CPU_OCI_TIMEOUT_EN
          wait_cnt_d = 8'd0;
`endif
        end
      end

      S_READ, S_WRITE: begin
        // Strobes are deliberately ignored while an access is in flight.
        if (!mem_waitrequest) begin
          if (state_q == S_READ) begin
            mon_d_d = mem_readdata;
          end
          if (inc_q) begin
            mon_a_d = mon_a_q + ADDR_W'(1);
          end
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
`ifdef SRAM_100_QSYS_CPU_OCI_TIMEOUT_EN
        else if (wait_cnt_q == TIMEOUT_LAST) begin
          // This edge is the TIMEOUT-th stalled one: give up, keep registers.
          ready_d = 1'b1;
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifndef SRAM_100_QSYS_CPU_OCI_TIMEOUT_EN
    error_d = 1'b0;
`endif
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mon_a_q <= '0;
      mon_d_q <= '0;
      inc_q   <= 1'b0;
      ready_q <= 1'b1;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mon_a_q <= mon_a_d;
      mon_d_q <= mon_d_d;
      inc_q   <= inc_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

`ifdef SRAM_100_QSYS_CPU_OCI_TIMEOUT_EN
  // Stall counter for the access timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  assign mem_read      = (state_q == S_READ);
  assign mem_write     = (state_q == S_WRITE);
  assign mem_address   = mon_a_q;
  assign mem_writedata = mon_d_q;
  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule

// File: tb/tb_sram_100_qsys_cpu_oci_monitor_access.sv
// Bench for sram_100_qsys_cpu_oci_monitor_access. Completed transfers are
// checked against an expected queue filled when each command is issued.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_sram_100_qsys_cpu_oci_monitor_access;

  localparam int W = 41; // {write, address[7:0], data[31:0]}

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic [7:0]  mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  sram_100_qsys_cpu_oci_monitor_access #(.ADDR_W(8), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_waitrequest(mem_waitrequest), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  // clock/reset block
  always #5 clk = ~clk;

  function automatic logic [37:0] jdo_a(input logic rd, input logic [7:0] addr);
    logic [37:0] j;
    j = '0;
    j[34] = rd;
    j[25:18] = addr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    logic [37:0] j;
    j = '0;
    j[34:3] = data;
    return j;
  endfunction

  // driver: one-cycle strobe; returns 1 unit after the sampling edge
  task automatic strobe(input logic a, input logic b, input logic na, input logic [37:0] j);
    @(posedge clk); #1;
    jdo = j;
    take_action_ocimem_a = a;
    take_action_ocimem_b = b;
    take_no_action_ocimem_a = na;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  // driver/slave: serve the pending request with 'waits' stall cycles and
  // score the completing transfer; returns on the falling edge after it ends
  task automatic serve(input int waits, input logic [31:0] rdata, output int req_cycles);
    logic [W-1:0] exp, got;
    bit done;
    req_cycles = 0;
    done = 0;
    mem_readdata = rdata;
    for (int guard = 0; guard < 1000; guard++) begin
      mem_waitrequest = (req_cycles < waits);
      @(negedge clk);
      if (!(mem_read || mem_write)) begin
        done = 1;
        break;
      end
      if (req_cycles == 0) begin
        vectors++;
        if (monitor_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL ready_busy: got %b want 0", monitor_ready);
        end
      end
      req_cycles++;
      if (!mem_waitrequest) begin
        got = {mem_write, mem_address, mem_write ? mem_writedata : mem_readdata};
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_xfer: got %h with empty queue", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            miscompares++;
            $display("FAIL xfer: got %h want %h", got, exp);
          end
        end
      end
      @(posedge clk); #1;
    end
    mem_waitrequest = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL access_bound: request still high after 1000 cycles");
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_waitrequest = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    vectors += 7;
    if (mem_read !== 1'b0) begin miscompares++; $display("FAIL rst_read: got %b want 0", mem_read); end
    if (mem_write !== 1'b0) begin miscompares++; $display("FAIL rst_write: got %b want 0", mem_write); end
    if (monitor_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", monitor_ready); end
    if (monitor_error !== 1'b0) begin miscompares++; $display("FAIL rst_error: got %b want 0", monitor_error); end
    if (MonDReg !== 32'h0) begin miscompares++; $display("FAIL rst_mondreg: got %h want 0", MonDReg); end
    if (mem_address !== 8'h0) begin miscompares++; $display("FAIL rst_addr: got %h want 0", mem_address); end
    if (mem_writedata !== 32'h0) begin miscompares++; $display("FAIL rst_wdata: got %h want 0", mem_writedata); end
  endtask

  task automatic test_addr_load_read();
    int rc;
    exp_q.push_back({1'b0, 8'h3C, 32'hDEADBEEF});
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 8'h3C));
    serve(0, 32'hDEADBEEF, rc);
    vectors += 4;
    if (rc !== 1) begin miscompares++; $display("FAIL load_read_cycles: got %0d want 1", rc); end
    if (MonDReg !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load_read_data: got %h want deadbeef", MonDReg); end
    if (monitor_ready !== 1'b1) begin miscompares++; $display("FAIL load_read_ready: got %b want 1", monitor_ready); end
    if (mem_address !== 8'h3C) begin miscompares++; $display("FAIL load_read_addr: got %h want 3c", mem_address); end
  endtask

  task automatic test_write_inc();
    int rc;
    // Address-only load: no request, flags untouched.
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 8'hFF));
    @(negedge clk);
    vectors += 3;
    if (mem_read !== 1'b0) begin miscompares++; $display("FAIL load_only_read: got %b want 0", mem_read); end
    if (mem_address !== 8'hFF) begin miscompares++; $display("FAIL load_only_addr: got %h want ff", mem_address); end
    if (monitor_ready !== 1'b1) begin miscompares++; $display("FAIL load_only_ready: got %b want 1", monitor_ready); end
    exp_q.push_back({1'b1, 8'hFF, 32'h12345678});
    strobe(1'b0, 1'b1, 1'b0, jdo_b(32'h12345678));
    serve(3, 32'h0, rc);
    vectors += 4;
    if (rc !== 4) begin miscompares++; $display("FAIL write_cycles: got %0d want 4", rc); end
    if (mem_address !== 8'h00) begin miscompares++; $display("FAIL write_wrap: got %h want 00", mem_address); end
    if (MonDReg !== 32'h12345678) begin miscompares++; $display("FAIL write_mondreg: got %h want 12345678", MonDReg); end
    if (monitor_ready !== 1'b1) begin miscompares++; $display("FAIL write_ready: got %b want 1", monitor_ready); end
  endtask

  task automatic test_burst_read();
    int rc;
    logic [31:0] rd;
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 8'h10));
    for (int i = 0; i < 3; i++) begin
      rd = $urandom;
      exp_q.push_back({1'b0, 8'(8'h10 + i), rd});
      strobe(1'b0, 1'b0, 1'b1, jdo);
      serve($urandom_range(0, 2), rd, rc);
    end
    vectors += 2;
    if (mem_address !== 8'h13) begin miscompares++; $display("FAIL burst_addr: got %h want 13", mem_address); end
    if (MonDReg !== rd) begin miscompares++; $display("FAIL burst_data: got %h want %h", MonDReg, rd); end
  endtask

  task automatic test_busy_drop();
    int rc;
    logic [31:0] rd;
    rd = 32'hC0FFEE01;
    exp_q.push_back({1'b0, 8'h20, rd});
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 8'h20));
    mem_waitrequest = 1'b1;
    mem_readdata = rd;
    @(posedge clk); #1;
    jdo = jdo_b(32'hAAAA5555);
    take_action_ocimem_b = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_b = 1'b0;
    serve(2, rd, rc);
    vectors += 4;
    if (rc !== 3) begin miscompares++; $display("FAIL drop_cycles: got %0d want 3", rc); end
    if (MonDReg !== rd) begin miscompares++; $display("FAIL drop_data: got %h want %h", MonDReg, rd); end
    if (mem_address !== 8'h20) begin miscompares++; $display("FAIL drop_addr: got %h want 20", mem_address); end
    @(negedge clk);
    if (mem_write !== 1'b0) begin miscompares++; $display("FAIL drop_write: got %b want 0", mem_write); end
  endtask

  task automatic test_random();
    int rc;
    logic [7:0]  addr_m;
    logic [31:0] dreg_m, d;
    addr_m = 8'($urandom_range(0, 255));
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, addr_m));
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        exp_q.push_back({1'b1, addr_m, d});
        strobe(1'b0, 1'b1, 1'b0, jdo_b(d));
        serve($urandom_range(0, 3), 32'h0, rc);
      end else begin
        exp_q.push_back({1'b0, addr_m, d});
        strobe(1'b0, 1'b0, 1'b1, jdo);
        serve($urandom_range(0, 3), d, rc);
      end
      dreg_m = d;
      addr_m = addr_m + 8'd1;
      vectors += 2;
      if (mem_address !== addr_m) begin miscompares++; $display("FAIL rand_addr[%0d]: got %h want %h", i, mem_address, addr_m); end
      if (MonDReg !== dreg_m) begin miscompares++; $display("FAIL rand_data[%0d]: got %h want %h", i, MonDReg, dreg_m); end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] prev;
    prev = MonDReg;
`ifdef SRAM_100_QSYS_CPU_OCI_TIMEOUT_EN
    begin
      int rc;
      strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 8'h40));
      serve(100000, 32'h0, rc);
      vectors += 5;
      if (rc !== 255) begin miscompares++; $display("FAIL to_cycles: got %0d want 255", rc); end
      if (monitor_error !== 1'b1) begin miscompares++; $display("FAIL to_error: got %b want 1", monitor_error); end
      if (monitor_ready !== 1'b1) begin miscompares++; $display("FAIL to_ready: got %b want 1", monitor_ready); end
      if (MonDReg !== prev) begin miscompares++; $display("FAIL to_data: got %h want %h", MonDReg, prev); end
      if (mem_address !== 8'h40) begin miscompares++; $display("FAIL to_addr: got %h want 40", mem_address); end
      exp_q.push_back({1'b0, 8'h40, 32'h5A5A0F0F});
      strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 8'h40));
      serve(0, 32'h5A5A0F0F, rc);
      vectors++;
      if (monitor_error !== 1'b0) begin miscompares++; $display("FAIL to_clear: got %b want 0", monitor_error); end
    end
`else
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 8'h40));
    mem_waitrequest = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    vectors += 4;
    if (mem_read !== 1'b1) begin miscompares++; $display("FAIL stall_read: got %b want 1", mem_read); end
    if (monitor_error !== 1'b0) begin miscompares++; $display("FAIL stall_error: got %b want 0", monitor_error); end
    if (monitor_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready: got %b want 0", monitor_ready); end
    if (MonDReg !== prev) begin miscompares++; $display("FAIL stall_data: got %h want %h", MonDReg, prev); end
    pulse_reset();
    vectors++;
    if (mem_read !== 1'b0) begin miscompares++; $display("FAIL stall_rst_read: got %b want 0", mem_read); end
`endif
  endtask

  task automatic test_reset_mid_write();
    strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 8'h55));
    strobe(1'b0, 1'b1, 1'b0, jdo_b(32'hFEEDF00D));
    mem_waitrequest = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (mem_write !== 1'b1) begin miscompares++; $display("FAIL mid_write_busy: got %b want 1", mem_write); end
    pulse_reset();
    vectors += 4;
    if (mem_write !== 1'b0) begin miscompares++; $display("FAIL mid_rst_write: got %b want 0", mem_write); end
    if (monitor_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready: got %b want 1", monitor_ready); end
    if (mem_address !== 8'h00) begin miscompares++; $display("FAIL mid_rst_addr: got %h want 00", mem_address); end
    if (MonDReg !== 32'h0) begin miscompares++; $display("FAIL mid_rst_data: got %h want 0", MonDReg); end
  endtask

  initial begin
    test_reset();
    test_addr_load_read();
    test_write_inc();
    test_burst_read();
    test_busy_drop();
    test_random();
    test_timeout();
    test_reset_mid_write();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
